ex_muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the EX stage, implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It accepts an operation from decode and runs a radix-2 shift-add (multiply) or restoring (divide) loop over WIDTH cycles. It holds the pipeline via `busy` and returns one result with a single-cycle `done` pulse. It sits beside the ALU and shares its operand muxes; the EX result mux selects `result` when `done` is high.

---
 rtl/ex_muldiv_seq_pkg.sv | 42 ++++
 rtl/ex_muldiv_seq_if.sv | 23 ++
 rtl/ex_muldiv_seq_addsub.sv | 13 +
 rtl/ex_muldiv_seq.sv | 170 +++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_seq_pkg.sv
// Shared types and decode helpers for the EX-stage iterative multiply/divide sequencer.
package ex_muldiv_seq_pkg;

   typedef enum logic [2:0] {
      MUL_FUNC3    = 3'b000,
      MULH_FUNC3   = 3'b001,
      MULHSU_FUNC3 = 3'b010,
      MULHU_FUNC3  = 3'b011,
      DIV_FUNC3    = 3'b100,
      DIVU_FUNC3   = 3'b101,
      REM_FUNC3    = 3'b110,
      REMU_FUNC3   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_CALC = 2'b01,
      MD_FIX  = 2'b10,
      MD_DONE = 2'b11
   } md_state_e;

   function automatic logic op_is_div(input md_op_e op);
      logic [2:0] f;
      f = op;
      return f[2];
   endfunction

   function automatic logic op_is_rem(input md_op_e op);
      logic [2:0] f;
      f = op;
      return f[2] & f[1];
   endfunction

   function automatic logic op_a_signed(input md_op_e op);
      return (op == MULH_FUNC3) || (op == MULHSU_FUNC3) || (op == DIV_FUNC3) || (op == REM_FUNC3);
   endfunction

   function automatic logic op_b_signed(input md_op_e op);
      return (op == MULH_FUNC3) || (op == DIV_FUNC3) || (op == REM_FUNC3);
   endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// Request/response bundle between decode/EX control and the multiply/divide sequencer.
interface ex_muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       funct3;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, funct3, a, b, flush,
      input  busy, done, result
   );

   modport slave (
      input  start, funct3, a, b, flush,
      output busy, done, result
   );
endinterface

// File: rtl/ex_muldiv_seq_addsub.sv
// Single adder/subtractor used for one shift-add or restoring-divide step per cycle.
module ex_muldiv_seq_addsub #(
   parameter int N = 33
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         sub,
   output logic [N-1:0] sum,
   output logic         cout
);
   // Subtract is x + ~y + 1; carry-out high means no borrow.
   assign {cout, sum} = {1'b0, x} + {1'b0, y ^ {N{sub}}} + {{N{1'b0}}, sub};
endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M iterative sequencer: radix-2 shift-add multiply and restoring divide over WIDTH cycles.
module ex_muldiv_seq
   import ex_muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   ex_muldiv_seq_if.slave bus
);
   localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   md_state_e        state_q, state_d;
   md_op_e           op_q, op_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] hi_q, hi_d;       // product upper half / remainder
   logic [WIDTH-1:0] lo_q, lo_d;       // multiplier then product lower half / quotient
   logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand / divisor
   logic [WIDTH-1:0] result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   md_op_e           start_op;
   logic             a_neg, b_neg, div_by_zero;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign start_op    = md_op_e'(bus.funct3);
   assign a_neg       = op_a_signed(start_op) & bus.a[WIDTH-1];
   assign b_neg       = op_b_signed(start_op) & bus.b[WIDTH-1];
   assign a_mag       = a_neg ? -bus.a : bus.a;
   assign b_mag       = b_neg ? -bus.b : bus.b;
   assign div_by_zero = op_is_div(start_op) && (bus.b == '0);

   logic             as_sub, as_cout;
   logic [WIDTH:0]   as_x, as_y, as_sum;

   // Divide feeds {rem, quot MSB} (the left-shifted remainder); multiply feeds the zero-extended accumulator.
   assign as_sub = op_is_div(op_q);
   assign as_x   = as_sub ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
   assign as_y   = (as_sub || lo_q[0]) ? {1'b0, opnd_q} : '0;

   ex_muldiv_seq_addsub #(
      .N (WIDTH + 1)
   ) u_add_and_subtract (
      .x    (as_x),
      .y    (as_y),
      .sub  (as_sub),
      .sum  (as_sum),
      .cout (as_cout)
   );

   logic [WIDTH-1:0] mulh_fix, quot_fix, rem_fix;

   // Upper half of the negated 2*WIDTH product: the lower half only contributes a carry when it is zero.
   assign mulh_fix = neg_q ? (~hi_q + WIDTH'(lo_q == '0)) : hi_q;
   assign quot_fix = neg_q ? -lo_q : lo_q;
   assign rem_fix  = neg_q ? -hi_q : hi_q;

   always_comb begin
      // NOTE: every _d defaults to its _q first so no path through this block can infer a latch.
      state_d  = state_q;
      op_d     = op_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      unique case (state_q)
         MD_IDLE: begin
            if (bus.start && !bus.flush) begin
               op_d   = start_op;
               cnt_d  = '0;
               busy_d = 1'b1;
               if (div_by_zero) begin
                  // Quotient all ones, remainder is raw a, and no sign fix-up.
                  hi_d    = bus.a;
                  lo_d    = '1;
                  opnd_d  = '0;
                  neg_d   = 1'b0;
                  state_d = MD_FIX;
               end else begin
                  hi_d    = '0;
                  lo_d    = op_is_div(start_op) ? a_mag : b_mag;
                  opnd_d  = op_is_div(start_op) ? b_mag : a_mag;
                  neg_d   = op_is_rem(start_op) ? a_neg : (a_neg ^ b_neg);
                  state_d = MD_CALC;
               end
            end
         end

         MD_CALC: begin
            if (!as_sub) begin
               hi_d = as_sum[WIDTH:1];
               lo_d = {as_sum[0], lo_q[WIDTH-1:1]};
            end else if (as_cout) begin
               hi_d = as_sum[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = as_x[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = MD_FIX;
            end
         end

         MD_FIX: begin
            unique case (op_q)
               MUL_FUNC3:                             result_d = lo_q;
               MULH_FUNC3, MULHSU_FUNC3, MULHU_FUNC3: result_d = mulh_fix;
               DIV_FUNC3, DIVU_FUNC3:                 result_d = quot_fix;
               REM_FUNC3, REMU_FUNC3:                 result_d = rem_fix;
            endcase
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = MD_DONE;
         end

         MD_DONE: begin
            state_d = MD_IDLE;
         end
      endcase

      if (bus.flush) begin
         state_d  = MD_IDLE;
         busy_d   = 1'b0;
         done_d   = 1'b0;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= MD_IDLE;
         op_q     <= MUL_FUNC3;
         neg_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge values computed above.
         state_q  <= state_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: vector table, random ops against a reference model, corner sequences.
module tb_ex_muldiv_seq;
   import ex_muldiv_seq_pkg::*;

   localparam int W = 32;

   typedef struct {
      string      name;
      md_op_e     op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] expv;
      int         lat;
   } vec_t;

   typedef struct {
      string      name;
      logic [W-1:0] expv;
   } sb_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   sb_t  sb_q[$];
   sb_t  mon_e;

   ex_muldiv_seq_if #(.WIDTH(W)) bus ();

   ex_muldiv_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("spurious_done", W'(bus.done), '0);
         end else begin
            mon_e = sb_q.pop_front();
            check({mon_e.name, "_result"}, bus.result, mon_e.expv);
            check({mon_e.name, "_busy_with_done"}, W'(bus.busy), '0);
         end
      end
   end

   function automatic logic [W-1:0] ref_model(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint       sa, sb, ua, ub;
      int           ia, ib;
      logic [63:0]  p;
      logic [W-1:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      ia = $signed(a);
      ib = $signed(b);
      r  = '0;
      case (op)
         MUL_FUNC3:    begin p = ua * ub; r = p[31:0];  end
         MULH_FUNC3:   begin p = sa * sb; r = p[63:32]; end
         MULHSU_FUNC3: begin p = sa * ub; r = p[63:32]; end
         MULHU_FUNC3:  begin p = ua * ub; r = p[63:32]; end
         DIV_FUNC3: begin
            if (b == '0) r = '1;
            else if (a == 32'h8000_0000 && b == '1) r = 32'h8000_0000;
            else r = ia / ib;
         end
         DIVU_FUNC3: r = (b == '0) ? '1 : a / b;
         REM_FUNC3: begin
            if (b == '0) r = a;
            else if (a == 32'h8000_0000 && b == '1) r = '0;
            else r = ia % ib;
         end
         REMU_FUNC3: r = (b == '0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Issues one op, optionally pokes start mid-run at cycle 'poke', and checks latency and busy length.
   task automatic run_op(input string name, input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] expv, input int exp_lat, input int poke);
      int lat;
      int busy_n;
      sb_q.push_back('{name, expv});
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = op;
      bus.a      = a;
      bus.b      = b;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.funct3 = 3'($urandom);
      bus.a      = $urandom;
      bus.b      = $urandom;
      lat    = 1;
      busy_n = 0;
      while (bus.done !== 1'b1 && lat < 60) begin
         if (bus.busy === 1'b1) busy_n++;
         bus.start = (lat == poke);
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      check({name, "_latency"}, W'(lat), W'(exp_lat));
      check({name, "_busy_cycles"}, W'(busy_n), W'(exp_lat - 1));
      @(negedge clk);
      check({name, "_done_pulse"}, W'(bus.done), '0);
      check({name, "_hold"}, bus.result, expv);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t         vecs[$];
      md_op_e       rop;
      logic [W-1:0] ra, rb;

      vecs.push_back('{"mul_7xneg3",     MUL_FUNC3,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
      vecs.push_back('{"mulhu_ones",     MULHU_FUNC3,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
      vecs.push_back('{"mulh_ones",      MULH_FUNC3,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34});
      vecs.push_back('{"mulhsu_ones",    MULHSU_FUNC3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
      vecs.push_back('{"mulh_min_sq",    MULH_FUNC3,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34});
      vecs.push_back('{"div_m7_2",       DIV_FUNC3,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34});
      vecs.push_back('{"rem_m7_2",       REM_FUNC3,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34});
      vecs.push_back('{"divu_100_7",     DIVU_FUNC3,   32'd100,        32'd7,         32'd14,        34});
      vecs.push_back('{"remu_100_7",     REMU_FUNC3,   32'd100,        32'd7,         32'd2,         34});
      vecs.push_back('{"divu_by_zero",   DIVU_FUNC3,   32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 2});
      vecs.push_back('{"rem_by_zero",    REM_FUNC3,    32'h0000_1234,  32'd0,         32'h0000_1234, 2});
      vecs.push_back('{"div_overflow",   DIV_FUNC3,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34});
      vecs.push_back('{"rem_overflow",   REM_FUNC3,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 34});

      bus.start  = 1'b0;
      bus.flush  = 1'b0;
      bus.funct3 = 3'b000;
      bus.a      = '0;
      bus.b      = '0;

      repeat (3) @(negedge clk);
      check("reset_busy",   W'(bus.busy), '0);
      check("reset_done",   W'(bus.done), '0);
      check("reset_result", bus.result,   '0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expv, vecs[i].lat, 0);
      end

      for (int i = 0; i < 8; i++) begin
         rop = md_op_e'(3'($urandom_range(0, 7)));
         ra  = $urandom;
         rb  = (i % 2 == 1) ? 32'($urandom_range(1, 13)) : $urandom;
         run_op($sformatf("rand%0d", i), rop, ra, rb, ref_model(rop, ra, rb),
                (op_is_div(rop) && rb == '0) ? 2 : 34, 0);
      end

      // start while busy must neither restart nor disturb the running divide
      run_op("start_while_busy", DIVU_FUNC3, 32'd100, 32'd7, 32'd14, 34, 5);
      repeat (40) @(negedge clk);

      // flush mid-multiply: back to idle, no done, result kept
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = MUL_FUNC3;
      bus.a      = 32'd3;
      bus.b      = 32'd5;
      @(negedge clk);
      bus.start  = 1'b0;
      repeat (8) @(negedge clk);
      bus.flush  = 1'b1;
      @(negedge clk);
      bus.flush  = 1'b0;
      check("flush_busy",   W'(bus.busy), '0);
      check("flush_done",   W'(bus.done), '0);
      check("flush_result", bus.result,   32'd14);

      // flush wins over a simultaneous start
      bus.start  = 1'b1;
      bus.flush  = 1'b1;
      bus.funct3 = DIVU_FUNC3;
      bus.a      = 32'd100;
      bus.b      = 32'd7;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.flush  = 1'b0;
      check("flush_vs_start_busy", W'(bus.busy), '0);
      run_op("after_flush", MUL_FUNC3, 32'd6, 32'd7, 32'd42, 34, 0);

      // asynchronous reset in the middle of a divide
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = DIV_FUNC3;
      bus.a      = 32'hFFFF_FFF9;
      bus.b      = 32'd2;
      @(negedge clk);
      bus.start  = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy",   W'(bus.busy), '0);
      check("midrst_done",   W'(bus.done), '0);
      check("midrst_result", bus.result,   '0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      check("postrst_result", bus.result, '0);

      check("scoreboard_empty", W'(sb_q.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
